// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic-array operand path: SRAM macro
// geometry/latency and the read-streamer FSM state encoding.
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_rd_streamer_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Synchronous power-of-two FIFO whose head is visible combinationally, so a
// written entry is presented the cycle after the write with no bubble.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and data
//   pop              read request (ignored when empty)
//   full, empty      occupancy flags
//   head             current head entry (zero while empty)
//   count            number of stored entries
// -----------------------------------------------------------------------------
module stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  // Gate the head so the stream data reads as zero whenever nothing is held.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    // A write into a full FIFO is only legal when the head leaves the same cycle.
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sram_rd_streamer.sv
// -----------------------------------------------------------------------------
// sram_rd_streamer
// Reads a block of bytes from the single-port SRAM wrapper and streams them
// out over valid/ready. Reads are only issued when the output FIFO is sure to
// have room for every outstanding byte, so returned data is never dropped.
// Ports:
//   CLK, RSTN                  clock, asynchronous active-low reset
//   i_Start/i_BaseAddr/i_Len   transfer request, accepted only in IDLE
//   o_Busy, o_Done             not-idle flag, one-cycle completion pulse
//   o_EN_R, o_Addr             registered SRAM read enable and address
//   i_SramData                 SRAM read data, valid RD_LAT cycles after o_EN_R
//   o_Data/o_Valid/i_Ready     output byte stream
// -----------------------------------------------------------------------------
module sram_rd_streamer
  import systolic_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int LEN_W      = 11,
  parameter int RD_LAT     = SRAM_RD_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              i_Start,
  input  logic [ADDR_W-1:0] i_BaseAddr,
  input  logic [LEN_W-1:0]  i_Len,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_EN_R,
  output logic [ADDR_W-1:0] o_Addr,
  input  logic [DATA_W-1:0] i_SramData,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Valid,
  input  logic              i_Ready
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W  = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              en_r_q, en_r_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [RD_LAT-1:0] infl_q, infl_d;

  logic              push, pop, fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [CRD_W-1:0]  inflight, occupancy;
  logic              credit_ok, drained;

  // Tail of the issue pipeline marks the cycle the SRAM data is valid.
  assign push    = infl_q[RD_LAT-1];
  assign pop     = ~fifo_empty & i_Ready;
  assign o_Valid = ~fifo_empty;
  assign o_Busy  = busy_q;
  assign o_Done  = done_q;
  assign o_EN_R  = en_r_q;
  assign o_Addr  = addr_q;

  // Credit: bytes already stored plus every read still travelling through
  // o_EN_R and the latency pipeline. Pops this cycle are not counted back.
  always_comb begin
    inflight = CRD_W'(en_r_q);
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CRD_W'(infl_q[i]);
    occupancy = CRD_W'(fifo_cnt) + inflight;
    credit_ok = (occupancy < CRD_W'(FIFO_DEPTH));
    // Finished once nothing is in flight and the FIFO empties this cycle.
    drained   = (inflight == '0) &&
                ((fifo_cnt == '0) || ((fifo_cnt == FCNT_W'(1)) && pop));
  end

  always_comb begin
    infl_d    = '0;
    infl_d[0] = en_r_q;
    for (int i = 1; i < RD_LAT; i++) infl_d[i] = infl_q[i-1];
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    en_r_d     = 1'b0;
    addr_d     = addr_q;
    nxt_addr_d = nxt_addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_Start) begin
          len_d      = i_Len;
          cnt_d      = '0;
          nxt_addr_d = i_BaseAddr;
          if (i_Len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            busy_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == len_q) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          en_r_d     = 1'b1;
          addr_d     = nxt_addr_q;
          // Address wraps silently at the top of the SRAM.
          nxt_addr_d = nxt_addr_q + 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_r_q     <= 1'b0;
      addr_q     <= '0;
      nxt_addr_q <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      infl_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_r_q     <= en_r_d;
      addr_q     <= addr_d;
      nxt_addr_q <= nxt_addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      infl_q     <= infl_d;
    end
  end

  stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTN),
    .push      (push),
    .push_data (i_SramData),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (o_Data),
    .count     (fifo_cnt)
  );

  // The credit rule must make a write into a full, non-draining FIFO impossible.
  fifo_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
    !(push && fifo_full && !pop));

endmodule
